// File: rtl/ball_physics_engine.sv
// Fixed-point ball physics shared by every game mode: gravity, debounced collision
// reflection with per-channel boost, wormhole teleports, speed limits and lives/respawn.
module ball_physics_engine #(
    parameter int                    FRAC_BITS      = 6,
    parameter int                    INITIAL_X      = 10,
    parameter int                    INITIAL_Y      = 210,
    parameter int                    LAUNCH_VX      = 150,
    parameter int                    LAUNCH_VY      = -150,
    parameter int                    MAX_SPEED      = 300,
    parameter int                    GRAVITY        = 3,
    parameter int                    DAMP           = 20,
    parameter int                    DAMP_THRESHOLD = 40,
    parameter int                    N_OBJ          = 4,
    parameter logic [8*N_OBJ-1:0]    OBJ_BOOST      = '0,
    parameter int                    N_TELE         = 2,
    parameter logic [22*N_TELE-1:0]  TELE_XY        = {11'd34, 11'd5, 11'd150, 11'd570},
    parameter int                    TELE_BOOST     = 20,
    parameter int                    LOSS_Y         = 480,
    parameter int                    LIVES          = 3,
    parameter int                    RESPAWN_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     launch,
    input  logic [N_OBJ-1:0]         collision,
    input  logic [3:0]               HitEdgeCode,
    input  logic [N_TELE-1:0]        teleport_req,
    output logic signed [10:0]       topLeftX,
    output logic signed [10:0]       topLeftY,
    output logic [2:0]               lives_left,
    output logic                     ball_lost,
    output logic                     gameOver,
    output logic                     active
);

    typedef enum logic [1:0] {IDLE, PLAY, LOST, GAME_OVER} stateType;

    localparam logic signed [31:0] SPAWN_X      = INITIAL_X <<< FRAC_BITS;
    localparam logic signed [31:0] SPAWN_Y      = INITIAL_Y <<< FRAC_BITS;
    localparam logic [2:0]         LIVES_INIT   = 3'(LIVES);
    localparam logic [15:0]        RESPAWN_LAST = 16'(RESPAWN_FRAMES - 1);

    stateType                state;
    logic signed [31:0]      posX, posY, vx, vy;
    logic signed [31:0]      pixY;
    logic [3:0]              pendEdge, edgeNow, hitEdge;
    logic [3:0][7:0]         boostEdge, hitBoost;
    logic [N_TELE-1:0]       pendTele, teleNow;
    logic [15:0]             respawnCnt;
    logic                    lossNow;
    logic                    teleHit;
    logic signed [10:0]      teleX, teleY;
    logic signed [31:0]      vx1, vy1, vx2, vy2, vy3;
    logic signed [31:0]      nextX, nextY, vxSat, vySat;

    function automatic logic signed [31:0] saturate(input logic signed [31:0] v);
        if (v > MAX_SPEED)
            return MAX_SPEED;
        if (v < -MAX_SPEED)
            return -MAX_SPEED;
        return v;
    endfunction

    // A zero speed counts as positive so a stalled ball leaves a wormhole moving.
    function automatic logic signed [31:0] addMagnitude(input logic signed [31:0] v);
        if (v < 0)
            return v - TELE_BOOST;
        return v + TELE_BOOST;
    endfunction

    assign topLeftX = posX[FRAC_BITS +: 11];
    assign topLeftY = posY[FRAC_BITS +: 11];
    assign pixY     = posY >>> FRAC_BITS;
    assign lossNow  = (state == PLAY) && (pixY >= LOSS_Y);

    always_comb begin
        hitEdge  = '0;
        hitBoost = boostEdge;
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (collision[i] && HitEdgeCode[e]) begin
                    hitEdge[e] = 1'b1;
                    if (OBJ_BOOST[8*i +: 8] > hitBoost[e])
                        hitBoost[e] = OBJ_BOOST[8*i +: 8];
                end
            end
        end
        edgeNow = pendEdge | hitEdge;
        teleNow = pendTele | teleport_req;
    end

    // Frame resolution: reflect, then teleport or move, then gravity and limits.
    always_comb begin
        vy1 = vy;
        if (edgeNow[0] && vy > 0)
            vy1 = (vy <= DAMP_THRESHOLD) ? -vy : -(vy - DAMP);
        else if (edgeNow[2] && vy < 0)
            vy1 = -vy + $signed({24'd0, hitBoost[2]});

        vx1 = vx;
        if (edgeNow[3] && vx < 0)
            vx1 = -vx + $signed({24'd0, hitBoost[3]});
        else if (edgeNow[1] && vx > 0)
            vx1 = -(vx + $signed({24'd0, hitBoost[1]}));

        teleHit = 1'b0;
        teleX   = '0;
        teleY   = '0;
        for (int j = N_TELE - 1; j >= 0; j--) begin
            if (teleNow[j]) begin
                teleHit = 1'b1;
                teleX   = TELE_XY[22*j +: 11];
                teleY   = TELE_XY[22*j+11 +: 11];
            end
        end

        if (teleHit) begin
            nextX = $signed({{21{teleX[10]}}, teleX}) <<< FRAC_BITS;
            nextY = $signed({{21{teleY[10]}}, teleY}) <<< FRAC_BITS;
            vx2   = addMagnitude(vx1);
            vy2   = addMagnitude(vy1);
        end else begin
            nextX = posX + vx1;
            nextY = posY + vy1;
            vx2   = vx1;
            vy2   = vy1;
        end

        vy3   = (vx2 != 0) ? vy2 + GRAVITY : vy2;
        vxSat = saturate(vx2);
        vySat = saturate(vy3);
    end

    // Pending flags default to clear; they only persist while playing between frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            posX       <= SPAWN_X;
            posY       <= SPAWN_Y;
            vx         <= '0;
            vy         <= '0;
            lives_left <= LIVES_INIT;
            pendEdge   <= '0;
            boostEdge  <= '0;
            pendTele   <= '0;
            respawnCnt <= '0;
            ball_lost  <= 1'b0;
            gameOver   <= 1'b0;
            active     <= 1'b0;
        end else begin
            ball_lost <= 1'b0;
            pendEdge  <= '0;
            boostEdge <= '0;
            pendTele  <= '0;
            case (state)
                IDLE, GAME_OVER: begin
                    posX <= SPAWN_X;
                    posY <= SPAWN_Y;
                    if (launch) begin
                        state      <= PLAY;
                        vx         <= LAUNCH_VX;
                        vy         <= LAUNCH_VY;
                        lives_left <= LIVES_INIT;
                        gameOver   <= 1'b0;
                        active     <= 1'b1;
                    end
                end
                PLAY: begin
                    if (lossNow) begin
                        ball_lost  <= 1'b1;
                        lives_left <= lives_left - 3'd1;
                        posX       <= SPAWN_X;
                        posY       <= SPAWN_Y;
                        vx         <= '0;
                        vy         <= '0;
                        respawnCnt <= '0;
                        active     <= 1'b0;
                        if (lives_left == 3'd1) begin
                            state    <= GAME_OVER;
                            gameOver <= 1'b1;
                        end else begin
                            state <= LOST;
                        end
                    end else if (startOfFrame) begin
                        posX <= nextX;
                        posY <= nextY;
                        vx   <= vxSat;
                        vy   <= vySat;
                    end else begin
                        pendEdge  <= edgeNow;
                        boostEdge <= hitBoost;
                        pendTele  <= teleNow;
                    end
                end
                LOST: begin
                    posX <= SPAWN_X;
                    posY <= SPAWN_Y;
                    vx   <= '0;
                    vy   <= '0;
                    if (startOfFrame) begin
                        if (respawnCnt == RESPAWN_LAST) begin
                            state      <= PLAY;
                            active     <= 1'b1;
                            vx         <= LAUNCH_VX;
                            vy         <= LAUNCH_VY;
                            respawnCnt <= '0;
                        end else begin
                            respawnCnt <= respawnCnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_physics_engine.sv
// Directed bench for ball_physics_engine: launch, reflections, boosts, teleports,
// saturation, lives/respawn and reset recovery with hand-computed expectations.
module tb_ball_physics_engine;

    logic              clk = 1'b0;
    logic              reset;
    logic              startOfFrame;
    logic              launch;
    logic [3:0]        collision;
    logic [3:0]        HitEdgeCode;
    logic [1:0]        teleport_req;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [2:0]        lives_left;
    logic              ball_lost;
    logic              gameOver;
    logic              active;

    int compared   = 0;
    int mismatched = 0;

    ball_physics_engine #(
        .OBJ_BOOST(32'h0000_1E00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .launch(launch),
        .collision(collision),
        .HitEdgeCode(HitEdgeCode),
        .teleport_req(teleport_req),
        .topLeftX(topLeftX),
        .topLeftY(topLeftY),
        .lives_left(lives_left),
        .ball_lost(ball_lost),
        .gameOver(gameOver),
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulseLaunch();
        launch = 1'b1;
        tick();
        launch = 1'b0;
    endtask

    task automatic frame(input logic [3:0] col, input logic [3:0] edg, input logic [1:0] tele);
        collision    = col;
        HitEdgeCode  = edg;
        teleport_req = tele;
        startOfFrame = 1'b1;
        tick();
        collision    = '0;
        HitEdgeCode  = '0;
        teleport_req = '0;
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic holdCollision(input logic [3:0] col, input logic [3:0] edg, input int cycles);
        collision   = col;
        HitEdgeCode = edg;
        repeat (cycles) tick();
        collision   = '0;
        HitEdgeCode = '0;
        tick();
    endtask

    task automatic runUntilLost(output bit seen);
        seen = 1'b0;
        for (int f = 0; f < 2000 && !seen; f++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            if (ball_lost) seen = 1'b1;
            else begin
                tick();
                seen = ball_lost;
            end
        end
    endtask

    task automatic test_reset();
        doReset();
        compared++; if (topLeftX !== 11'sd10) begin mismatched++; $display("[TB] FAIL reset_x: got %0d expected 10", topLeftX); end
        compared++; if (topLeftY !== 11'sd210) begin mismatched++; $display("[TB] FAIL reset_y: got %0d expected 210", topLeftY); end
        compared++; if (lives_left !== 3'd3) begin mismatched++; $display("[TB] FAIL reset_lives: got %0d expected 3", lives_left); end
        compared++; if ({active, gameOver, ball_lost} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {active, gameOver, ball_lost}); end
        frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (topLeftX !== 11'sd10 || active !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_parked: got x=%0d active=%b expected x=10 active=0", topLeftX, active); end
    endtask

    task automatic test_launch();
        doReset();
        pulseLaunch();
        compared++; if (active !== 1'b1) begin mismatched++; $display("[TB] FAIL launch_active: got %b expected 1", active); end
        frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (topLeftX !== 11'sd12) begin mismatched++; $display("[TB] FAIL launch_x: got %0d expected 12", topLeftX); end
        compared++; if (topLeftY !== 11'sd207) begin mismatched++; $display("[TB] FAIL launch_y: got %0d expected 207", topLeftY); end
        compared++; if (dut.vx !== 32'sd150) begin mismatched++; $display("[TB] FAIL launch_vx: got %0d expected 150", dut.vx); end
        compared++; if (dut.vy !== -32'sd147) begin mismatched++; $display("[TB] FAIL launch_vy: got %0d expected -147", dut.vy); end
    endtask

    task automatic test_bottom_bounce();
        doReset();
        pulseLaunch();
        frame(4'b0001, 4'b0100, 2'b00);
        compared++; if (dut.vy !== 32'sd153) begin mismatched++; $display("[TB] FAIL top_reflect_vy: got %0d expected 153", dut.vy); end
        frame(4'b0001, 4'b0001, 2'b00);
        compared++; if (dut.vy !== -32'sd130) begin mismatched++; $display("[TB] FAIL damped_vy: got %0d expected -130", dut.vy); end
        compared++; if (topLeftY !== 11'sd210 || topLeftX !== 11'sd14) begin mismatched++; $display("[TB] FAIL damped_pos: got %0d,%0d expected 14,210", topLeftX, topLeftY); end
        frame(4'b0001, 4'b0001, 2'b00);
        compared++; if (dut.vy !== -32'sd127) begin mismatched++; $display("[TB] FAIL bottom_wrong_sign: got %0d expected -127", dut.vy); end
        doReset();
        pulseLaunch();
        repeat (60) frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (dut.vy !== 32'sd30) begin mismatched++; $display("[TB] FAIL fall_vy: got %0d expected 30", dut.vy); end
        frame(4'b0001, 4'b0001, 2'b00);
        compared++; if (dut.vy !== -32'sd27) begin mismatched++; $display("[TB] FAIL lossless_vy: got %0d expected -27", dut.vy); end
        compared++; if (topLeftY !== 11'sd151) begin mismatched++; $display("[TB] FAIL lossless_y: got %0d expected 151", topLeftY); end
    endtask

    task automatic test_debounce_saturation();
        doReset();
        pulseLaunch();
        frame(4'b0000, 4'b0000, 2'b01);
        compared++; if (dut.vx !== 32'sd170) begin mismatched++; $display("[TB] FAIL tele_vx: got %0d expected 170", dut.vx); end
        holdCollision(4'b0010, 4'b0010, 5);
        frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (dut.vx !== -32'sd200) begin mismatched++; $display("[TB] FAIL debounce_vx: got %0d expected -200", dut.vx); end
        frame(4'b0010, 4'b1000, 2'b00);
        frame(4'b0011, 4'b0010, 2'b00);
        compared++; if (dut.vx !== -32'sd260) begin mismatched++; $display("[TB] FAIL max_boost_vx: got %0d expected -260", dut.vx); end
        frame(4'b0010, 4'b1000, 2'b00);
        compared++; if (dut.vx !== 32'sd290) begin mismatched++; $display("[TB] FAIL left_boost_vx: got %0d expected 290", dut.vx); end
        holdCollision(4'b0010, 4'b0010, 5);
        frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (dut.vx !== -32'sd300) begin mismatched++; $display("[TB] FAIL sat_vx: got %0d expected -300", dut.vx); end
        pulseLaunch();
        compared++; if (dut.vx !== -32'sd300 || active !== 1'b1) begin mismatched++; $display("[TB] FAIL launch_in_play: got vx=%0d active=%b expected -300 1", dut.vx, active); end
        frame(4'b0010, 4'b0010, 2'b00);
        compared++; if (dut.vx !== -32'sd300) begin mismatched++; $display("[TB] FAIL right_wrong_sign: got %0d expected -300", dut.vx); end
        frame(4'b0010, 4'b1010, 2'b00);
        compared++; if (dut.vx !== 32'sd300) begin mismatched++; $display("[TB] FAIL conflict_vx: got %0d expected 300", dut.vx); end
    endtask

    task automatic test_teleport();
        doReset();
        pulseLaunch();
        frame(4'b0001, 4'b0010, 2'b11);
        compared++; if (topLeftX !== 11'sd570 || topLeftY !== 11'sd150) begin mismatched++; $display("[TB] FAIL tele0_pos: got %0d,%0d expected 570,150", topLeftX, topLeftY); end
        compared++; if (dut.vx !== -32'sd170 || dut.vy !== -32'sd167) begin mismatched++; $display("[TB] FAIL tele0_speed: got %0d,%0d expected -170,-167", dut.vx, dut.vy); end
        frame(4'b0000, 4'b0000, 2'b10);
        compared++; if (topLeftX !== 11'sd5 || topLeftY !== 11'sd34) begin mismatched++; $display("[TB] FAIL tele1_pos: got %0d,%0d expected 5,34", topLeftX, topLeftY); end
        compared++; if (dut.vx !== -32'sd190 || dut.vy !== -32'sd184) begin mismatched++; $display("[TB] FAIL tele1_speed: got %0d,%0d expected -190,-184", dut.vx, dut.vy); end
        repeat (14) frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (topLeftY !== -11'sd2) begin mismatched++; $display("[TB] FAIL floor_y: got %0d expected -2", topLeftY); end
        compared++; if (topLeftX !== -11'sd37) begin mismatched++; $display("[TB] FAIL floor_x: got %0d expected -37", topLeftX); end
    endtask

    task automatic test_lives();
        bit seen;
        doReset();
        pulseLaunch();
        for (int n = 0; n < 3; n++) begin
            runUntilLost(seen);
            compared++; if (!seen) begin mismatched++; $display("[TB] FAIL loss_%0d_timeout: got no ball_lost expected a pulse", n); end
            compared++; if (lives_left !== 3'(2 - n)) begin mismatched++; $display("[TB] FAIL loss_%0d_lives: got %0d expected %0d", n, lives_left, 2 - n); end
            tick();
            compared++; if (ball_lost !== 1'b0 || active !== 1'b0 || topLeftY !== 11'sd210) begin mismatched++; $display("[TB] FAIL loss_%0d_park: got lost=%b active=%b y=%0d expected 0 0 210", n, ball_lost, active, topLeftY); end
            if (n < 2) begin
                compared++; if (gameOver !== 1'b0) begin mismatched++; $display("[TB] FAIL loss_%0d_gameover: got %b expected 0", n, gameOver); end
                pulseLaunch();
                repeat (29) frame(4'b0000, 4'b0000, 2'b00);
                compared++; if (active !== 1'b0) begin mismatched++; $display("[TB] FAIL respawn_%0d_early: got %b expected 0", n, active); end
                frame(4'b0000, 4'b0000, 2'b00);
                compared++; if (active !== 1'b1 || dut.vx !== 32'sd150) begin mismatched++; $display("[TB] FAIL respawn_%0d: got active=%b vx=%0d expected 1 150", n, active, dut.vx); end
            end
        end
        compared++; if (gameOver !== 1'b1) begin mismatched++; $display("[TB] FAIL game_over: got %b expected 1", gameOver); end
        pulseLaunch();
        compared++; if (lives_left !== 3'd3 || active !== 1'b1 || gameOver !== 1'b0) begin mismatched++; $display("[TB] FAIL restart: got lives=%0d active=%b go=%b expected 3 1 0", lives_left, active, gameOver); end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        doReset();
        pulseLaunch();
        runUntilLost(seen);
        tick();
        repeat (10) frame(4'b0000, 4'b0000, 2'b00);
        collision   = 4'b0001;
        HitEdgeCode = 4'b0100;
        doReset();
        collision   = '0;
        HitEdgeCode = '0;
        compared++; if (lives_left !== 3'd3 || active !== 1'b0 || topLeftX !== 11'sd10 || topLeftY !== 11'sd210) begin mismatched++; $display("[TB] FAIL midreset_state: got lives=%0d active=%b pos=%0d,%0d expected 3 0 10,210", lives_left, active, topLeftX, topLeftY); end
        repeat (25) frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (active !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_countdown: got %b expected 0", active); end
        pulseLaunch();
        holdCollision(4'b0001, 4'b0100, 1);
        doReset();
        pulseLaunch();
        frame(4'b0000, 4'b0000, 2'b00);
        compared++; if (dut.vy !== -32'sd147 || topLeftY !== 11'sd207) begin mismatched++; $display("[TB] FAIL midreset_pending: got vy=%0d y=%0d expected -147 207", dut.vy, topLeftY); end
    endtask

    initial begin
        reset        = 1'b0;
        startOfFrame = 1'b0;
        launch       = 1'b0;
        collision    = '0;
        HitEdgeCode  = '0;
        teleport_req = '0;
        test_reset();
        test_launch();
        test_bottom_bounce();
        test_debounce_saturation();
        test_teleport();
        test_lives();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ball_physics_engine.md
Name: ball_physics_engine

Overview:
- Parametrised successor to the per-mode ball movement/collision blocks.
- Single fixed-point physics engine for the ball: gravity, per-frame debounced collision reflection from N generic collider channels, per-channel speed boost, N teleport (wormhole) targets, two-axis speed saturation, and a lives/respawn state machine.
- Sits between the collision-detection matrix and the ball square/bitmap drawers; one instance serves every game mode.

Parameters:
- FRAC_BITS, 6, fixed-point fraction bits (position resolution 1/2^FRAC_BITS pixel)
- INITIAL_X, 10, spawn X in pixels
- INITIAL_Y, 210, spawn Y in pixels
- LAUNCH_VX, 150, X speed loaded on launch, fixed-point units per frame
- LAUNCH_VY, -150, Y speed loaded on launch
- MAX_SPEED, 300, magnitude limit for both axes
- GRAVITY, 3, added to vy each frame
- DAMP, 20, magnitude removed on a bottom-edge bounce
- DAMP_THRESHOLD, 40, bottom bounce is lossless when vy <= this
- N_OBJ, 4, number of collider channels
- OBJ_BOOST, 0, N_OBJ x 8-bit packed unsigned boost per channel (channel i = bits [8i+7:8i])
- N_TELE, 2, number of teleport targets
- TELE_XY, {150,570,34,5}, N_TELE x (11-bit Y, 11-bit X) packed targets in pixels; entry 0 = (Y 150, X 570)
- TELE_BOOST, 20, magnitude added to both axes on teleport
- LOSS_Y, 480, ball lost when topLeftY >= LOSS_Y
- LIVES, 3, lives per game (1..7)
- RESPAWN_FRAMES, 30, frames parked before auto-relaunch

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- startOfFrame  in  1  one-cycle pulse per frame
- launch  in  1  one-cycle start/restart request
- collision  in  N_OBJ  per-channel collision with the ball, any cycle
- HitEdgeCode  in  4  ball edge touched: [0] bottom, [1] right, [2] top, [3] left
- teleport_req  in  N_TELE  ball entered wormhole i
- topLeftX  out  11 signed  pixel X = posX >>> FRAC_BITS
- topLeftY  out  11 signed  pixel Y = posY >>> FRAC_BITS
- lives_left  out  3  remaining lives
- ball_lost  out  1  one-cycle pulse on loss
- gameOver  out  1  level, high in GAME_OVER
- active  out  1  high in PLAY

Behaviour:
- Reset, sync and active-high, overrides everything: state IDLE; pos = spawn; vx = vy = 0; lives_left = LIVES; all pending flags cleared; ball_lost = 0; gameOver = 0.
- Datapath: posX/posY/vx/vy are 32-bit signed. Pixel outputs use an arithmetic shift (floor), not division.
- States:
  - IDLE: ball parked at spawn. launch -> PLAY with vx = LAUNCH_VX, vy = LAUNCH_VY.
  - PLAY: physics runs (below).
  - LOST: ball parked at spawn, speeds 0. After RESPAWN_FRAMES startOfFrame pulses -> PLAY with launch speeds.
  - GAME_OVER: gameOver = 1, ball parked. launch -> PLAY, lives_left = LIVES.
- Pending capture, PLAY only, every cycle:
  - collision[i] & HitEdgeCode[e] sets pend_edge[e].
  - boost_e is updated to max(boost_e, OBJ_BOOST[i]).
  - teleport_req[j] sets pend_tele[j].
  - Flags are sticky until the next startOfFrame, so each axis reflects at most once per frame (debounce).
  - Inputs asserted in the same cycle as startOfFrame are included in that frame's resolution.
- Resolution on startOfFrame in PLAY, single cycle, in this order, using registered values:
  1. Reflect Y. Bottom pend with vy > 0: vy = -vy if vy <= DAMP_THRESHOLD, else -(vy - DAMP). Top pend with vy < 0: vy = -vy + boost_top.
  2. Reflect X. Left pend with vx < 0: vx = -vx + boost_left. Right pend with vx > 0: vx = -(vx + boost_right).
  3. Teleport. The lowest-index pend_tele wins: pos = target << FRAC_BITS; |vx| and |vy| each increase by TELE_BOOST, sign preserved. If vx == 0 it becomes +TELE_BOOST.
  4. Otherwise move: pos += (vx, vy) from step 1-2 results.
  5. Gravity: vy += GRAVITY only if vx != 0.
  6. Saturate vx and vy to [-MAX_SPEED, +MAX_SPEED]. Clear all pending flags and boosts.
- Conflicting flags on one axis (top and bottom, or left and right): only the rule matching the current sign fires.
- Loss check, PLAY, every cycle: topLeftY >= LOSS_Y triggers loss.
  - ball_lost pulses for one cycle and lives_left decrements.
  - Position and speeds snap to spawn/0 on the next edge.
  - Next state is GAME_OVER if lives_left was 1, else LOST.
  - Loss has priority over a same-cycle startOfFrame.
- launch is ignored in PLAY and LOST.
- Reset asserted mid-frame or mid-countdown discards all pending state.

Test Plan:
- Reset, launch, one SOF with no collisions -> posX = 640 + 150 = 790 (topLeftX 12), posY = 13440 - 150 = 13290 (topLeftY 207), vy = -147, vx = 150, active = 1.
- Channel 0 bottom collision (boost 0) with vy = 100, then SOF -> vy moves as -80 and becomes -77 after gravity. Repeat with vy = 30 -> moves as -30.
- vx = 290, channel 1 right edge with OBJ_BOOST = 30; collision held high 5 cycles before SOF -> exactly one reflection, vx = -300 (saturated).
- teleport_req = 2'b11 with vx = -100, vy = 50, then SOF -> topLeftX = 570, topLeftY = 150, vx = -120, vy = 73.
- Drive the ball to topLeftY = 480 three times with LIVES = 3 -> ball_lost pulses 3 times; lives 2, 1, 0; LOST then relaunch after 30 SOFs; third loss -> gameOver = 1; launch -> lives 3, active = 1.
- Assert reset during a LOST countdown with a collision pending -> next cycle IDLE, spawn position, lives 3, and no reflection on the next SOF.
